// File: rtl/td4_core_param.sv
// td4_core_param: parametrised TD4 core, DATA_W-bit regs, 2^ADDR_W program words.
// Ports: clock/reset, start/stop/step control, prog_* loader, in_port, out_port/out_valid, halted, pc.
module td4_core_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W+3:0] prog_data,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int IW    = DATA_W + 4;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_HALT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_A    = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;
  localparam logic [1:0] SRC_IN   = 2'd3;

  logic [IW-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              c_q, c_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ov_q, ov_d;

  logic [IW-1:0]     instr;
  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [1:0]        src_sel;
  logic              imm_en;
  logic              wr_a, wr_b, wr_out;
  logic              is_jmp, is_jnc, is_hlt;
  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum;
  logic              exec;

  // Fetch is combinational, so a write on the same edge as a step
  // cannot affect the instruction being executed.
  assign instr = mem_q[pc_q];
  assign op    = instr[IW-1:DATA_W];
  assign imm   = instr[DATA_W-1:0];

  always_comb begin
    src_sel = SRC_ZERO;
    imm_en  = 1'b1;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    wr_out  = 1'b0;
    is_jmp  = 1'b0;
    is_jnc  = 1'b0;
    is_hlt  = 1'b0;
    case (op)
      4'b0000: begin src_sel = SRC_A;  wr_a = 1'b1; end
      4'b0101: begin src_sel = SRC_B;  wr_b = 1'b1; end
      4'b0011: begin wr_a = 1'b1; end
      4'b0111: begin wr_b = 1'b1; end
      4'b0001: begin src_sel = SRC_B;  wr_a = 1'b1; end
      4'b0100: begin src_sel = SRC_A;  wr_b = 1'b1; end
      4'b0010: begin src_sel = SRC_IN; wr_a = 1'b1; end
      4'b0110: begin src_sel = SRC_IN; wr_b = 1'b1; end
      4'b1001: begin src_sel = SRC_B;  wr_out = 1'b1; end
      4'b1011: begin wr_out = 1'b1; end
      4'b1111: begin is_jmp = 1'b1; end
      4'b1110: begin is_jnc = 1'b1; end
      4'b1000: begin imm_en = 1'b0; is_hlt = 1'b1; end
      default: begin imm_en = 1'b0; end
    endcase
  end

  always_comb begin
    case (src_sel)
      SRC_A:   src = a_q;
      SRC_B:   src = b_q;
      SRC_IN:  src = in_port;
      default: src = '0;
    endcase
    sum = {1'b0, src} + {1'b0, (imm_en ? imm : {DATA_W{1'b0}})};
  end

  // stop suppresses any execute on its edge, including a step.
  assign exec = !stop && ((state_q == ST_RUN) || step);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    pc_d    = pc_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    if (exec) begin
      c_d = sum[DATA_W];
      if (wr_a)   a_d   = sum[DATA_W-1:0];
      if (wr_b)   b_d   = sum[DATA_W-1:0];
      if (wr_out) out_d = sum[DATA_W-1:0];
      ov_d = wr_out;
      // JNC tests the carry held before this edge.
      if (is_jmp || (is_jnc && !c_q))
        pc_d = imm[ADDR_W-1:0];
      else
        pc_d = pc_q + ADDR_W'(1);
    end
    if (state_q == ST_HALT && start) state_d = ST_RUN;
    if (exec && is_hlt)              state_d = ST_HALT;
    if (stop)                        state_d = ST_HALT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_HALT;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      pc_q    <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  // Program memory survives reset.
  always_ff @(posedge clock) begin
    if (prog_we && state_q == ST_HALT)
      mem_q[prog_addr] <= prog_data;
  end

  assign out_port  = out_q;
  assign out_valid = ov_q;
  assign halted    = (state_q == ST_HALT);
  assign pc        = pc_q;

endmodule

// File: tb/tb_td4_core_param.sv
// tb_td4_core_param: directed tests for td4_core_param.
// Instances: 4/4 core and 8/5 core sharing clock and reset.
module tb_td4_core_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       start4 = 0, stop4 = 0, step4 = 0, we4 = 0;
  logic [3:0] addr4 = '0;
  logic [7:0] data4 = '0;
  logic [3:0] in4 = '0;
  logic [3:0] out4;
  logic       ov4, halted4;
  logic [3:0] pc4;

  logic        start8 = 0, stop8 = 0, step8 = 0, we8 = 0;
  logic [4:0]  addr8 = '0;
  logic [11:0] data8 = '0;
  logic [7:0]  in8 = '0;
  logic [7:0]  out8;
  logic        ov8, halted8;
  logic [4:0]  pc8;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  td4_core_param #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .start(start4), .stop(stop4), .step(step4),
    .prog_we(we4), .prog_addr(addr4), .prog_data(data4),
    .in_port(in4), .out_port(out4), .out_valid(ov4),
    .halted(halted4), .pc(pc4)
  );

  td4_core_param #(.DATA_W(8), .ADDR_W(5)) dut8 (
    .clock(clock), .reset(reset),
    .start(start8), .stop(stop8), .step(step8),
    .prog_we(we8), .prog_addr(addr8), .prog_data(data8),
    .in_port(in8), .out_port(out8), .out_valid(ov8),
    .halted(halted8), .pc(pc8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic load4(input logic [3:0] a, input logic [7:0] d);
    we4 = 1'b1; addr4 = a; data4 = d;
    tick();
    we4 = 1'b0;
  endtask

  task automatic load8(input logic [4:0] a, input logic [11:0] d);
    we8 = 1'b1; addr8 = a; data8 = d;
    tick();
    we8 = 1'b0;
  endtask

  task automatic run4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic step4_pulse();
    step4 = 1'b1;
    tick();
    step4 = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    nvec++; if (halted4 !== 1'b1) begin nerr++; $display("FAIL rst_halted got %b exp 1", halted4); end
    nvec++; if (pc4 !== 4'd0) begin nerr++; $display("FAIL rst_pc got %h exp 0", pc4); end
    nvec++; if (out4 !== 4'd0) begin nerr++; $display("FAIL rst_out got %h exp 0", out4); end
    nvec++; if (ov4 !== 1'b0) begin nerr++; $display("FAIL rst_ov got %b exp 0", ov4); end
    nvec++; if (dut4.a_q !== 4'd0 || dut4.b_q !== 4'd0 || dut4.c_q !== 1'b0) begin
      nerr++; $display("FAIL rst_abc got %h %h %b exp 0 0 0", dut4.a_q, dut4.b_q, dut4.c_q);
    end
    reset = 1'b0;
    tick();
    tick();
    nvec++; if (halted4 !== 1'b1 || pc4 !== 4'd0) begin
      nerr++; $display("FAIL rst_stay got halted=%b pc=%h exp 1 0", halted4, pc4);
    end
  endtask

  task automatic test_add_hlt();
    rst_pulse();
    load4(4'd0, 8'h3C);
    load4(4'd1, 8'h05);
    load4(4'd2, 8'h80);
    run4();
    nvec++; if (halted4 !== 1'b0 || pc4 !== 4'd0) begin
      nerr++; $display("FAIL start_run got halted=%b pc=%h exp 0 0", halted4, pc4);
    end
    tick();
    nvec++; if (dut4.a_q !== 4'hC || pc4 !== 4'd1) begin
      nerr++; $display("FAIL mov_a got a=%h pc=%h exp c 1", dut4.a_q, pc4);
    end
    tick();
    nvec++; if (dut4.a_q !== 4'h1 || dut4.c_q !== 1'b1 || pc4 !== 4'd2) begin
      nerr++; $display("FAIL add_a got a=%h c=%b pc=%h exp 1 1 2", dut4.a_q, dut4.c_q, pc4);
    end
    tick();
    nvec++; if (dut4.c_q !== 1'b0 || halted4 !== 1'b1 || pc4 !== 4'd3) begin
      nerr++; $display("FAIL hlt got c=%b halted=%b pc=%h exp 0 1 3", dut4.c_q, halted4, pc4);
    end
  endtask

  task automatic test_out();
    logic [3:0] eo [8];
    logic       ev [8];
    logic [3:0] ep [8];
    eo = '{4'h5, 4'h5, 4'h4, 4'h4, 4'h5, 4'h5, 4'h4, 4'h4};
    ev = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ep = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    rst_pulse();
    load4(4'd0, 8'hB5);
    load4(4'd1, 8'h73);
    load4(4'd2, 8'h91);
    load4(4'd3, 8'hF0);
    run4();
    for (int e = 0; e < 8; e++) begin
      tick();
      nvec++; if (out4 !== eo[e] || ov4 !== ev[e] || pc4 !== ep[e]) begin
        nerr++;
        $display("FAIL out_seq%0d got out=%h ov=%b pc=%h exp %h %b %h",
                 e, out4, ov4, pc4, eo[e], ev[e], ep[e]);
      end
    end
    stop4 = 1'b1;
    tick();
    stop4 = 1'b0;
    nvec++; if (halted4 !== 1'b1 || pc4 !== 4'd0 || ov4 !== 1'b0) begin
      nerr++; $display("FAIL stop got halted=%b pc=%h ov=%b exp 1 0 0", halted4, pc4, ov4);
    end
  endtask

  task automatic test_jnc();
    rst_pulse();
    load4(4'd0, 8'h33);
    load4(4'd1, 8'h0F);
    load4(4'd2, 8'hE1);
    load4(4'd3, 8'h80);
    run4();
    tick(); tick();
    nvec++; if (dut4.a_q !== 4'h2 || dut4.c_q !== 1'b1 || pc4 !== 4'd2) begin
      nerr++; $display("FAIL jnc_add got a=%h c=%b pc=%h exp 2 1 2", dut4.a_q, dut4.c_q, pc4);
    end
    tick();
    nvec++; if (pc4 !== 4'd3 || dut4.c_q !== 1'b0) begin
      nerr++; $display("FAIL jnc_fall got pc=%h c=%b exp 3 0", pc4, dut4.c_q);
    end
    tick();
    nvec++; if (halted4 !== 1'b1 || pc4 !== 4'd4) begin
      nerr++; $display("FAIL jnc_hlt got halted=%b pc=%h exp 1 4", halted4, pc4);
    end
    rst_pulse();
    load4(4'd0, 8'h30);
    run4();
    tick(); tick();
    nvec++; if (dut4.a_q !== 4'hF || dut4.c_q !== 1'b0) begin
      nerr++; $display("FAIL loop_add1 got a=%h c=%b exp f 0", dut4.a_q, dut4.c_q);
    end
    tick();
    nvec++; if (pc4 !== 4'd1) begin nerr++; $display("FAIL loop_taken got pc=%h exp 1", pc4); end
    tick();
    nvec++; if (dut4.a_q !== 4'hE || dut4.c_q !== 1'b1) begin
      nerr++; $display("FAIL loop_add2 got a=%h c=%b exp e 1", dut4.a_q, dut4.c_q);
    end
    tick();
    nvec++; if (pc4 !== 4'd3) begin nerr++; $display("FAIL loop_exit got pc=%h exp 3", pc4); end
    tick();
    nvec++; if (halted4 !== 1'b1 || pc4 !== 4'd4) begin
      nerr++; $display("FAIL loop_hlt got halted=%b pc=%h exp 1 4", halted4, pc4);
    end
  endtask

  task automatic test_pc_wrap();
    rst_pulse();
    for (int i = 0; i < 16; i++) load4(4'(i), 8'hA0);
    run4();
    repeat (15) tick();
    nvec++; if (pc4 !== 4'd15) begin nerr++; $display("FAIL wrap_15 got pc=%h exp f", pc4); end
    tick();
    nvec++; if (pc4 !== 4'd0) begin nerr++; $display("FAIL wrap_0 got pc=%h exp 0", pc4); end
    tick();
    nvec++; if (pc4 !== 4'd1 || halted4 !== 1'b0) begin
      nerr++; $display("FAIL wrap_cont got pc=%h halted=%b exp 1 0", pc4, halted4);
    end
    stop4 = 1'b1;
    tick();
    stop4 = 1'b0;
  endtask

  task automatic test_step();
    rst_pulse();
    load4(4'd0, 8'hB7);
    load4(4'd1, 8'hB8);
    load4(4'd2, 8'hB9);
    load4(4'd3, 8'h80);
    load4(4'd4, 8'hB1);
    load4(4'd5, 8'hB6);
    load4(4'd6, 8'hF5);
    for (int i = 0; i < 3; i++) begin
      step4_pulse();
      nvec++; if (pc4 !== 4'(i + 1) || out4 !== 4'(7 + i) || ov4 !== 1'b1 || halted4 !== 1'b1) begin
        nerr++; $display("FAIL step%0d got pc=%h out=%h ov=%b halted=%b exp %h %h 1 1",
                         i, pc4, out4, ov4, halted4, 4'(i + 1), 4'(7 + i));
      end
      tick();
      nvec++; if (pc4 !== 4'(i + 1) || ov4 !== 1'b0) begin
        nerr++; $display("FAIL step%0d_idle got pc=%h ov=%b exp %h 0", i, pc4, ov4, 4'(i + 1));
      end
    end
    run4();
    we4 = 1'b1; addr4 = 4'd4; data4 = 8'hB2;
    tick();
    we4 = 1'b0;
    nvec++; if (halted4 !== 1'b1 || pc4 !== 4'd4) begin
      nerr++; $display("FAIL run_hlt got halted=%b pc=%h exp 1 4", halted4, pc4);
    end
    step4_pulse();
    nvec++; if (out4 !== 4'h1 || pc4 !== 4'd5) begin
      nerr++; $display("FAIL we_in_run got out=%h pc=%h exp 1 5", out4, pc4);
    end
    we4 = 1'b1; addr4 = 4'd5; data4 = 8'hB5; step4 = 1'b1;
    tick();
    we4 = 1'b0; step4 = 1'b0;
    nvec++; if (out4 !== 4'h6 || pc4 !== 4'd6) begin
      nerr++; $display("FAIL we_step got out=%h pc=%h exp 6 6", out4, pc4);
    end
    step4_pulse();
    nvec++; if (pc4 !== 4'd5) begin nerr++; $display("FAIL step_jmp got pc=%h exp 5", pc4); end
    step4_pulse();
    nvec++; if (out4 !== 4'h5) begin nerr++; $display("FAIL we_new got out=%h exp 5", out4); end
  endtask

  task automatic test_wide();
    rst_pulse();
    load8(5'd0, 12'h200);
    load8(5'd1, 12'h020);
    load8(5'd2, 12'h400);
    load8(5'd3, 12'h900);
    load8(5'd4, 12'hF3F);
    load8(5'd31, 12'hF00);
    in8 = 8'hF0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    nvec++; if (dut8.a_q !== 8'hF0 || pc8 !== 5'd1) begin
      nerr++; $display("FAIL w_in got a=%h pc=%h exp f0 01", dut8.a_q, pc8);
    end
    tick();
    nvec++; if (dut8.a_q !== 8'h10 || dut8.c_q !== 1'b1) begin
      nerr++; $display("FAIL w_add got a=%h c=%b exp 10 1", dut8.a_q, dut8.c_q);
    end
    tick(); tick();
    nvec++; if (out8 !== 8'h10 || ov8 !== 1'b1 || pc8 !== 5'd4) begin
      nerr++; $display("FAIL w_out got out=%h ov=%b pc=%h exp 10 1 04", out8, ov8, pc8);
    end
    tick();
    nvec++; if (pc8 !== 5'h1F || ov8 !== 1'b0) begin
      nerr++; $display("FAIL w_jmp got pc=%h ov=%b exp 1f 0", pc8, ov8);
    end
    tick();
    nvec++; if (pc8 !== 5'd0) begin nerr++; $display("FAIL w_jmp0 got pc=%h exp 00", pc8); end
    repeat (4) tick();
    reset = 1'b1;
    #1;
    nvec++; if (halted8 !== 1'b1 || pc8 !== 5'd0 || out8 !== 8'h0 || ov8 !== 1'b0) begin
      nerr++; $display("FAIL w_async_rst got halted=%b pc=%h out=%h ov=%b exp 1 00 00 0",
                       halted8, pc8, out8, ov8);
    end
    reset = 1'b0;
    tick(); tick();
    nvec++; if (halted8 !== 1'b1 || pc8 !== 5'd0) begin
      nerr++; $display("FAIL w_rst_stay got halted=%b pc=%h exp 1 00", halted8, pc8);
    end
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    nvec++; if (out8 !== 8'h10 || ov8 !== 1'b1 || pc8 !== 5'd4) begin
      nerr++; $display("FAIL w_kept got out=%h ov=%b pc=%h exp 10 1 04", out8, ov8, pc8);
    end
  endtask

  initial begin
    test_reset();
    test_add_hlt();
    test_out();
    test_jnc();
    test_pc_wrap();
    test_step();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
